// File: rtl/speed_tracker_mc.sv
// Multi-channel car speed tracker: per-ID entry timestamps, a bit-serial restoring
// divider computing DIST_K / elapsed_ticks, a result FIFO and latest-two registers.
module speed_tracker_mc #(
    parameter int WIDTH      = 8,
    parameter int ID_W       = 4,
    parameter int TS_W       = 16,
    parameter int SPD_W      = 8,
    parameter int PRESC      = 50000,
    parameter int DIST_K     = 36000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_car,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [ID_W-1:0]  o_res_id,
    output logic [SPD_W-1:0] o_res_speed,
    output logic [ID_W-1:0]  o_id0,
    output logic [SPD_W-1:0] o_speed0,
    output logic [ID_W-1:0]  o_id1,
    output logic [SPD_W-1:0] o_speed1,
    output logic             o_busy,
    output logic             o_drop,
    output logic             o_orphan,
    output logic             o_overflow
);
    localparam int N   = TS_W + SPD_W;
    localparam int NCH = 1 << ID_W;
    localparam int PW  = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int CW  = $clog2(N + 1);
    localparam int FW  = $clog2(FIFO_DEPTH);
    localparam int RW  = ID_W + SPD_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DIV   = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    // Clamp the quotient to the speed range; a zero elapsed time also saturates.
    function automatic logic [SPD_W-1:0] sat_speed(input logic [N-1:0] quo, input logic [TS_W-1:0] el);
        logic [SPD_W-1:0] res;
        if ((el == {TS_W{1'b0}}) || (quo[N-1:SPD_W] != {(N-SPD_W){1'b0}})) begin
            res = {SPD_W{1'b1}};
        end else begin
            res = quo[SPD_W-1:0];
        end
        return res;
    endfunction

    state_t              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [TS_W-1:0]     tick_q, tick_d;
    logic [NCH-1:0]      valid_q, valid_d;
    logic [TS_W-1:0]     stamp_q [NCH];
    logic [TS_W-1:0]     stamp_d [NCH];
    logic                pend_valid_q, pend_valid_d;
    logic [ID_W-1:0]     pend_id_q, pend_id_d;
    logic [TS_W-1:0]     pend_el_q, pend_el_d;
    logic [ID_W-1:0]     job_id_q, job_id_d;
    logic [TS_W-1:0]     job_el_q, job_el_d;
    logic [TS_W-1:0]     rem_q, rem_d;
    logic [N-1:0]        quo_q, quo_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [RW-1:0]       mem_q [FIFO_DEPTH];
    logic [RW-1:0]       mem_d [FIFO_DEPTH];
    logic [FW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FW:0]         count_q, count_d;
    logic [ID_W-1:0]     id0_q, id0_d, id1_q, id1_d;
    logic [SPD_W-1:0]    spd0_q, spd0_d, spd1_q, spd1_d;
    logic                orphan_q, orphan_d, drop_q, drop_d, overflow_q, overflow_d;

    logic [ID_W-1:0]     ev_id_s;
    logic [TS_W-1:0]     ev_el_s;
    logic                exit_ok_s, pend_take_s, direct_s, pop_s, push_s, push_ok_s;
    logic [SPD_W-1:0]    res_spd_s;
    logic [TS_W:0]       trial_s;
    logic [TS_W-1:0]     diff_s;
    logic [RW-1:0]       head_s;
    logic                unused_car_s;

    assign unused_car_s = ^i_car[WIDTH-2:ID_W];

    // Next-state logic: tick base, event intake, pending slot, divider FSM and FIFO.
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        tick_d       = tick_q;
        valid_d      = valid_q;
        stamp_d      = stamp_q;
        pend_valid_d = pend_valid_q;
        pend_id_d    = pend_id_q;
        pend_el_d    = pend_el_q;
        job_id_d     = job_id_q;
        job_el_d     = job_el_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        cnt_d        = cnt_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        id0_d        = id0_q;
        id1_d        = id1_q;
        spd0_d       = spd0_q;
        spd1_d       = spd1_q;
        overflow_d   = overflow_q;
        orphan_d     = 1'b0;
        drop_d       = 1'b0;

        ev_id_s     = i_car[ID_W-1:0];
        ev_el_s     = tick_q - stamp_q[ev_id_s];
        exit_ok_s   = i_start && i_car[WIDTH-1] && valid_q[ev_id_s];
        pend_take_s = pend_valid_q && ((state_q == S_IDLE) || (state_q == S_WRITE));
        direct_s    = exit_ok_s && (state_q == S_IDLE) && !pend_valid_q;
        pop_s       = i_res_ready && (count_q != {(FW+1){1'b0}});
        push_s      = (state_q == S_WRITE);
        push_ok_s   = push_s && ((count_q != (FW+1)'(FIFO_DEPTH)) || pop_s);
        res_spd_s   = sat_speed(quo_q, job_el_q);
        trial_s     = {rem_q, quo_q[N-1]};
        diff_s      = trial_s[TS_W-1:0] - job_el_q;

        if (presc_q == PW'(PRESC - 1)) begin
            presc_d = {PW{1'b0}};
            tick_d  = tick_q + TS_W'(1);
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (i_start && !i_car[WIDTH-1]) begin
            stamp_d[ev_id_s] = tick_q;
            valid_d[ev_id_s] = 1'b1;
        end else if (i_start && !valid_q[ev_id_s]) begin
            orphan_d = 1'b1;
        end else if (i_start) begin
            valid_d[ev_id_s] = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // The pending slot frees in the same cycle it hands its job to LOAD.
        if (pend_take_s) begin
            pend_valid_d = 1'b0;
        end else begin
            pend_valid_d = pend_valid_q;
        end
        if (exit_ok_s && !direct_s) begin
            if (!pend_valid_q || pend_take_s) begin
                pend_valid_d = 1'b1;
                pend_id_d    = ev_id_s;
                pend_el_d    = ev_el_s;
            end else begin
                drop_d = 1'b1;
            end
        end else begin
            drop_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (pend_valid_q) begin
                    state_d  = S_LOAD;
                    job_id_d = pend_id_q;
                    job_el_d = pend_el_q;
                end else if (direct_s) begin
                    state_d  = S_LOAD;
                    job_id_d = ev_id_s;
                    job_el_d = ev_el_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                rem_d   = {TS_W{1'b0}};
                quo_d   = N'(DIST_K);
                cnt_d   = {CW{1'b0}};
                state_d = S_DIV;
            end
            S_DIV: begin
                if (trial_s >= {1'b0, job_el_q}) begin
                    rem_d = diff_s;
                    quo_d = {quo_q[N-2:0], 1'b1};
                end else begin
                    rem_d = trial_s[TS_W-1:0];
                    quo_d = {quo_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_WRITE: begin
                id1_d  = id0_q;
                spd1_d = spd0_q;
                id0_d  = job_id_q;
                spd0_d = res_spd_s;
                if (pend_valid_q) begin
                    state_d  = S_LOAD;
                    job_id_d = pend_id_q;
                    job_el_d = pend_el_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + FW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = {job_id_q, res_spd_s};
            wr_ptr_d        = wr_ptr_q + FW'(1);
        end else if (push_s) begin
            overflow_d = 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        count_d = count_q + (FW+1)'(push_ok_s) - (FW+1)'(pop_s);
    end

    // FIFO head, forced to zero while empty.
    always_comb begin
        if (count_q != {(FW+1){1'b0}}) begin
            head_s = mem_q[rd_ptr_q];
        end else begin
            head_s = {RW{1'b0}};
        end
    end

    // State registers; reset abandons any division in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            presc_q      <= {PW{1'b0}};
            tick_q       <= {TS_W{1'b0}};
            valid_q      <= {NCH{1'b0}};
            stamp_q      <= '{default: {TS_W{1'b0}}};
            pend_valid_q <= 1'b0;
            pend_id_q    <= {ID_W{1'b0}};
            pend_el_q    <= {TS_W{1'b0}};
            job_id_q     <= {ID_W{1'b0}};
            job_el_q     <= {TS_W{1'b0}};
            rem_q        <= {TS_W{1'b0}};
            quo_q        <= {N{1'b0}};
            cnt_q        <= {CW{1'b0}};
            mem_q        <= '{default: {RW{1'b0}}};
            wr_ptr_q     <= {FW{1'b0}};
            rd_ptr_q     <= {FW{1'b0}};
            count_q      <= {(FW+1){1'b0}};
            id0_q        <= {ID_W{1'b0}};
            id1_q        <= {ID_W{1'b0}};
            spd0_q       <= {SPD_W{1'b0}};
            spd1_q       <= {SPD_W{1'b0}};
            orphan_q     <= 1'b0;
            drop_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            tick_q       <= tick_d;
            valid_q      <= valid_d;
            stamp_q      <= stamp_d;
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
            pend_el_q    <= pend_el_d;
            job_id_q     <= job_id_d;
            job_el_q     <= job_el_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            cnt_q        <= cnt_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            id0_q        <= id0_d;
            id1_q        <= id1_d;
            spd0_q       <= spd0_d;
            spd1_q       <= spd1_d;
            orphan_q     <= orphan_d;
            drop_q       <= drop_d;
            overflow_q   <= overflow_d;
        end
    end

    assign o_res_valid = (count_q != {(FW+1){1'b0}});
    assign o_res_id    = head_s[RW-1:SPD_W];
    assign o_res_speed = head_s[SPD_W-1:0];
    assign o_id0       = id0_q;
    assign o_speed0    = spd0_q;
    assign o_id1       = id1_q;
    assign o_speed1    = spd1_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_drop      = drop_q;
    assign o_orphan    = orphan_q;
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_speed_tracker_mc.sv
// Self-checking bench for speed_tracker_mc: directed scenarios plus random events
// scored against a tick/stamp/queue model of the car timing rules.
module tb_speed_tracker_mc;
    localparam int PRESC = 10;
    localparam int LAT   = 16 + 8 + 3;
    localparam int WLAT  = 10 + 8 + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_car = 8'h00;
    logic       i_res_ready = 1'b1;
    logic       o_res_valid, o_busy, o_drop, o_orphan, o_overflow;
    logic [3:0] o_res_id, o_id0, o_id1;
    logic [7:0] o_res_speed, o_speed0, o_speed1;

    logic       w_start = 1'b0;
    logic [7:0] w_car = 8'h00;
    logic       w_ready = 1'b1;
    logic       w_res_valid, w_busy, w_drop, w_orphan, w_overflow;
    logic [3:0] w_res_id, w_id0, w_id1;
    logic [7:0] w_res_speed, w_speed0, w_speed1;

    int n_checks = 0;
    int n_fail   = 0;
    int mcyc     = 0;
    bit m_valid [16];
    int m_stamp [16];
    int p_id = 0;
    int p_spd = 0;

    speed_tracker_mc #(.PRESC(PRESC)) u_dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_car(i_car),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_id(o_res_id), .o_res_speed(o_res_speed),
        .o_id0(o_id0), .o_speed0(o_speed0), .o_id1(o_id1), .o_speed1(o_speed1),
        .o_busy(o_busy), .o_drop(o_drop), .o_orphan(o_orphan), .o_overflow(o_overflow)
    );

    // Narrow-timestamp instance so the tick wrap is reachable in a short run.
    speed_tracker_mc #(.PRESC(1), .TS_W(10)) u_wrap (
        .clk(clk), .rst(rst), .i_start(w_start), .i_car(w_car),
        .o_res_valid(w_res_valid), .i_res_ready(w_ready),
        .o_res_id(w_res_id), .o_res_speed(w_res_speed),
        .o_id0(w_id0), .o_speed0(w_speed0), .o_id1(w_id1), .o_speed1(w_speed1),
        .o_busy(w_busy), .o_drop(w_drop), .o_orphan(w_orphan), .o_overflow(w_overflow)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; the tick seen by an event follows from it.
    always @(posedge clk or posedge rst) begin
        if (rst) mcyc <= 0;
        else     mcyc <= mcyc + 1;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int m_tick();
        return (mcyc / PRESC) % 65536;
    endfunction

    function automatic int exp_speed(input int el);
        int q;
        if (el == 0) return 255;
        q = 36000 / el;
        return (q > 255) ? 255 : q;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s: wait bound expired", tag);
    endtask

    task automatic wait_tick(input int t);
        int n = 0;
        while (m_tick() != t && n < 20000) begin step(); n++; end
        if (n >= 20000) bound_fail("wait_tick");
    endtask

    task automatic align();
        int n = 0;
        while ((mcyc % PRESC) != 0 && n < 2 * PRESC) begin step(); n++; end
    endtask

    task automatic send_ev(input bit gate, input int id, output bit orphan, output int el);
        logic [2:0] junk;
        logic [3:0] id4;
        junk = 3'($urandom_range(0, 7));
        id4 = 4'(id);
        orphan = 1'b0;
        el = 0;
        if (!gate) begin
            m_stamp[id] = m_tick();
            m_valid[id] = 1'b1;
        end else if (!m_valid[id]) begin
            orphan = 1'b1;
        end else begin
            el = (m_tick() - m_stamp[id] + 65536) % 65536;
            m_valid[id] = 1'b0;
        end
        i_car = {gate, junk, id4};
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_res(input string tag, input int id, input int spd);
        int n = 0;
        while (!o_res_valid && n < 60) begin step(); n++; end
        chk({tag, "_valid"}, o_res_valid, 1);
        chk({tag, "_id"}, o_res_id, id);
        chk({tag, "_speed"}, o_res_speed, spd);
        chk({tag, "_id0"}, o_id0, id);
        chk({tag, "_speed0"}, o_speed0, spd);
        chk({tag, "_id1"}, o_id1, p_id);
        chk({tag, "_speed1"}, o_speed1, p_spd);
        p_id = id;
        p_spd = spd;
        step();
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        bit seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (o_res_valid) seen = 1'b1;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        bit orph;
        int el, n, w_stamp, w_el, base;
        int f_id [5];
        int f_spd [5];

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", o_res_valid, 0);
        chk("rst_res_id", o_res_id, 0);
        chk("rst_res_speed", o_res_speed, 0);
        chk("rst_id0", o_id0, 0);
        chk("rst_speed0", o_speed0, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_drop", o_drop, 0);
        chk("rst_orphan", o_orphan, 0);
        chk("rst_overflow", o_overflow, 0);
        repeat (3) step();
        rst = 1'b0;

        // Basic: entry at tick 0, exit at tick 400, check latency
        send_ev(1'b0, 3, orph, el);
        wait_tick(400);
        send_ev(1'b1, 3, orph, el);
        chk("basic_busy", o_busy, 1);
        n = 1;
        while (!o_res_valid && n < 60) begin step(); n++; end
        chk("basic_latency", n, LAT);
        wait_res("basic", 3, exp_speed(el));
        chk("basic_popped", o_res_valid, 0);
        chk("basic_idle", o_busy, 0);

        // Saturation: zero elapsed, then elapsed 90 ticks
        align();
        send_ev(1'b0, 5, orph, el);
        send_ev(1'b1, 5, orph, el);
        wait_res("sat_zero", 5, exp_speed(el));
        send_ev(1'b0, 5, orph, el);
        wait_tick(m_stamp[5] + 90);
        send_ev(1'b1, 5, orph, el);
        wait_res("sat_90", 5, exp_speed(el));

        // Orphan exit on an ID never entered
        send_ev(1'b1, 7, orph, el);
        chk("orphan_pulse", o_orphan, orph);
        step();
        chk("orphan_single", o_orphan, 0);
        check_quiet("orphan_fifo_quiet", 40);

        // Wrap on the narrow instance: stamp 1000, exit at wrapped tick 376
        n = 0;
        while ((mcyc % 1024) != 1000 && n < 2100) begin step(); n++; end
        if (n >= 2100) bound_fail("wrap_entry_wait");
        w_stamp = mcyc % 1024;
        w_car = 8'h01;
        w_start = 1'b1;
        step();
        w_start = 1'b0;
        n = 0;
        while ((mcyc % 1024) != 376 && n < 2100) begin step(); n++; end
        if (n >= 2100) bound_fail("wrap_exit_wait");
        w_el = ((mcyc % 1024) - w_stamp + 1024) % 1024;
        w_car = 8'h81;
        w_start = 1'b1;
        step();
        w_start = 1'b0;
        n = 1;
        while (!w_res_valid && n < 60) begin step(); n++; end
        chk("wrap_latency", n, WLAT);
        chk("wrap_id", w_res_id, 1);
        chk("wrap_speed", w_res_speed, exp_speed(w_el));

        // Back-to-back exits: third one is dropped
        base = m_tick();
        send_ev(1'b0, 4, orph, el);
        wait_tick(base + 400);
        send_ev(1'b0, 1, orph, el);
        wait_tick(base + 600);
        send_ev(1'b0, 2, orph, el);
        wait_tick(base + 800);
        send_ev(1'b1, 1, orph, f_id[0]);
        send_ev(1'b1, 2, orph, f_id[1]);
        chk("b2b_no_drop", o_drop, 0);
        send_ev(1'b1, 4, orph, el);
        chk("b2b_drop", o_drop, 1);
        step();
        chk("b2b_drop_single", o_drop, 0);
        wait_res("b2b_first", 1, exp_speed(f_id[0]));
        wait_res("b2b_second", 2, exp_speed(f_id[1]));
        check_quiet("b2b_no_third", 60);
        send_ev(1'b1, 4, orph, el);
        chk("b2b_dropped_id_cleared", o_orphan, orph);

        // FIFO full: five results with the sink stalled
        i_res_ready = 1'b0;
        base = m_tick();
        for (int k = 0; k < 5; k++) send_ev(1'b0, 8 + k, orph, el);
        for (int k = 0; k < 5; k++) begin
            wait_tick(base + 200 + 100 * k);
            send_ev(1'b1, 8 + k, orph, el);
            f_id[k] = 8 + k;
            f_spd[k] = exp_speed(el);
            repeat (40) step();
        end
        chk("full_overflow", o_overflow, 1);
        chk("full_id0", o_id0, f_id[4]);
        chk("full_speed0", o_speed0, f_spd[4]);
        chk("full_id1", o_id1, f_id[3]);
        chk("full_speed1", o_speed1, f_spd[3]);
        i_res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("full_pop_valid", o_res_valid, 1);
            chk("full_pop_id", o_res_id, f_id[k]);
            chk("full_pop_speed", o_res_speed, f_spd[k]);
            step();
        end
        chk("full_drained", o_res_valid, 0);
        chk("full_head_zero", o_res_id, 0);
        p_id = f_id[4];
        p_spd = f_spd[4];

        // Reset ten cycles into the division
        send_ev(1'b0, 6, orph, el);
        wait_tick(m_tick() + 50);
        send_ev(1'b1, 6, orph, el);
        repeat (11) step();
        chk("mid_busy_before", o_busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_busy", o_busy, 0);
        chk("mid_valid", o_res_valid, 0);
        chk("mid_id0", o_id0, 0);
        chk("mid_speed0", o_speed0, 0);
        chk("mid_id1", o_id1, 0);
        chk("mid_speed1", o_speed1, 0);
        chk("mid_overflow", o_overflow, 0);
        for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
        p_id = 0;
        p_spd = 0;
        step();
        rst = 1'b0;
        check_quiet("mid_aborted", 40);
        send_ev(1'b1, 6, orph, el);
        chk("mid_orphan", o_orphan, orph);
        step();
        chk("mid_orphan_single", o_orphan, 0);

        // Random events on a few IDs, spaced so the divider is idle at each exit
        for (int e = 0; e < 24; e++) begin
            bit g;
            int id;
            g = 1'($urandom_range(0, 1));
            id = $urandom_range(0, 3);
            send_ev(g, id, orph, el);
            chk("rnd_orphan", o_orphan, orph);
            if (g && !orph) wait_res("rnd", id, exp_speed(el));
            repeat ($urandom_range(30, 800)) step();
        end
        chk("end_overflow", o_overflow, 0);
        chk("end_drop", o_drop, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/speed_tracker_mc.md
Name: speed_tracker_mc

Overview:
Parametrised multi-channel successor of the single-pair speed calculator. It takes UART car-event bytes (entry or exit gate plus car ID), timestamps them per ID, and computes speed = DIST_K / elapsed_ticks with a bit-serial divider, saturating on overflow. Results go into a ready/valid result FIFO and into "latest two" registers that feed the LCD driver directly.

Parameters:
WIDTH, 8, event byte width; bit WIDTH-1 is the gate flag (0 = entry, 1 = exit).
ID_W, 4, car ID width; ID = i_car[ID_W-1:0]; 2^ID_W tracked channels; bits between are ignored.
TS_W, 16, tick timestamp width (wraps modulo 2^TS_W).
SPD_W, 8, speed result width.
PRESC, 50000, clk cycles per tick (1 ms at 50 MHz).
DIST_K, 36000, numerator (10 m gate spacing, km/h with ms ticks); must fit TS_W+SPD_W bits.
FIFO_DEPTH, 4, result FIFO entries (power of 2).

Ports:
clk  in  1  system clock, single clock domain.
rst  in  1  asynchronous, active-high reset.
i_start  in  1  one-cycle strobe; i_car valid (uart rx_done).
i_car  in  WIDTH  event byte.
o_res_valid  out  1  FIFO non-empty.
i_res_ready  in  1  pop when high with o_res_valid.
o_res_id  out  ID_W  FIFO head ID.
o_res_speed  out  SPD_W  FIFO head speed.
o_id0 / o_speed0  out  ID_W / SPD_W  most recent result.
o_id1 / o_speed1  out  ID_W / SPD_W  previous result.
o_busy  out  1  divider running.
o_drop  out  1  one-cycle pulse: exit event lost (divider busy, pending full).
o_orphan  out  1  one-cycle pulse: exit with no valid entry for that ID.
o_overflow  out  1  sticky: result lost due to full FIFO; cleared only by rst.

Behaviour:
- Reset (async, immediate): all outputs 0, all ID valid bits cleared, timestamps 0, prescaler/tick 0, FIFO empty, pending empty, divider IDLE. Reset mid-division aborts without output.
- Tick: prescaler counts 0..PRESC-1; on wrap, tick counter increments (mod 2^TS_W).
- Entry event (i_start, gate 0): stamp[id] <= current tick, valid[id] <= 1 next cycle; a re-entry overwrites. Entry is always accepted, even while busy.
- Exit event (gate 1): if !valid[id] -> o_orphan pulse next cycle, nothing else happens. Else elapsed = (tick - stamp[id]) mod 2^TS_W, valid[id] <= 0, {id, elapsed} goes to the divider if IDLE, else to the 1-deep pending register. If pending is full: o_drop pulse, valid[id] is still cleared.
- Divider FSM: IDLE -> LOAD (1 cycle) -> DIV (TS_W+SPD_W cycles, restoring, 1 quotient bit per cycle) -> WRITE (1 cycle) -> IDLE, or -> LOAD directly if pending is valid (pending is consumed).
- Result: quotient saturates to 2^SPD_W-1 if it exceeds SPD_W bits or if elapsed == 0.
- Latency: exit strobe in cycle t with divider IDLE -> outputs update at cycle t+TS_W+SPD_W+3 (27 with defaults). o_busy is high from LOAD through WRITE.
- WRITE: o_id1/o_speed1 <= o_id0/o_speed0; o_id0/o_speed0 <= new result; push to FIFO.
- FIFO full: push is dropped and o_overflow is set; the last-two registers still update. A push and pop in the same cycle while full is legal and is not an overflow.
- Pop while empty: ignored. FIFO head outputs are 0 when empty.
- An entry event for an ID whose exit is still being divided is independent: elapsed was captured at exit acceptance.

Test Plan:
(bench overrides PRESC=10)
- Basic: entry id 3 at tick 0, exit id 3 at tick 400, i_res_ready=1 -> o_res_id=3, o_res_speed=90, o_id0=3, o_speed0=90; valid strobe arrives 27 cycles after the exit strobe.
- Saturation: entry/exit id 5 at the same tick -> speed 255; entry at tick 10, exit at tick 100 (36000/90=400) -> speed 255.
- Wrap: entry id 1 at tick 65500, exit at tick 364 (wrapped, elapsed 400) -> speed 90. Exit on id 7 with no entry -> single o_orphan pulse, FIFO unchanged.
- Back-to-back: three exits (ids 1, 2, 4; elapsed 400, 200, 800) on consecutive strobes while busy -> id 4 dropped with an o_drop pulse; FIFO yields (1,90) then (2,180); o_id0=2/o_speed0=180, o_id1=1/o_speed1=90.
- FIFO full: i_res_ready=0, five valid results -> first four retained in order, o_overflow=1, o_id0 is the fifth result. Then assert ready -> four pops, o_res_valid=0.
- Reset mid-division: assert rst 10 cycles into DIV -> all outputs 0 immediately; a later exit on the same ID gives o_orphan.
